shared_lin_map_pipe: RTL and testbench
======================================

// Module: shared_lin_map_pipe
// PURPOSE
// - Parametrised, pipelined successor of the AES S-box output linear map for threshold implementations (TI).
// - Applies the same 8x8 GF(2) inverse-isomorphism map independently to each of NUM_SHARES byte shares.
// - Optionally adds the AES affine constant 0x63 to share 0 only.
// - Sits between the shared GF(2^4)-tower inverter and MixColumns, with a valid/ready handshake and PIPE_DEPTH register stages.
// PARAMETERS
// NUM_SHARES  3  number of byte shares processed in parallel (legal 2..8)
// PIPE_DEPTH  1  register stages between input and output (legal 1..4)
// PORTS
// clk        in   1              rising-edge clock
// rst        in   1              synchronous reset, active-high
// in_valid   in   1              input beat valid
// in_ready   out  1              block can accept a beat this cycle
// in_mode    in   1              0: linear map only; 1: linear map, then XOR 0x63 onto share 0
// in_shares  in   8*NUM_SHARES   share i in bits [8i+7:8i]
// out_valid  out  1              output beat valid
// out_ready  in   1              downstream accepts a beat this cycle
// out_shares out  8*NUM_SHARES   mapped shares, same packing as input
// BEHAVIOUR
// - Map per share, C -> D (input bit Cn, output bit Dn), XOR only:
//   - D7=C5^C3
//   - D6=C7^C3
//   - D5=C6^C0
//   - D4=C7^C5^C3
//   - D3=C7^C6^C5^C4^C3
//   - D2=C6^C5^C3^C2^C0
//   - D1=C5^C4^C1
//   - D0=C6^C4^C1
// - Mode 1 XORs 0x63 into share 0's mapped value only; shares 1..NUM_SHARES-1 are never given a constant.
// - No cross-share logic anywhere; each share's datapath depends only on that share and the mode (TI non-completeness).
// - Pipeline: stages s=0..PIPE_DEPTH-1, each holding {valid_s, mode_s, data_s}.
//   - Stage 0 captures in_shares and in_mode on an input transfer.
//   - Map and constant are computed combinationally from stage 0 and registered into stage 1, or into the output register when PIPE_DEPTH=1.
//   - The output is always a register; nothing is combinational from input to output.
// - Handshake: transfer occurs when valid&ready on the same edge.
//   - Stage s may load when it is empty or when stage s+1 (or out_ready for the last stage) accepts its contents this cycle.
//   - in_ready = stage-0 load condition.
//   - in_ready depends on out_ready combinationally, with no combinational path from in_valid to in_ready.
//   - out_valid = valid of the last stage; out_shares = its data.
// - Latency: PIPE_DEPTH cycles from input transfer to out_valid when not stalled.
//   - Throughput: 1 beat/cycle with out_ready held high.
// - Stall: while out_valid=1 and out_ready=0, out_shares and out_valid are held stable, and the pipeline fills.
//   - When all PIPE_DEPTH stages are valid, in_ready=0 and no beat is lost or duplicated.
// - Simultaneous output accept and input accept on a full pipeline: all stages advance in one edge and occupancy is unchanged.
// - Ordering: strict FIFO, and each beat keeps its own mode.
// - Reset (rst=1 on a clock edge) clears all valid bits and data registers to 0, regardless of in-flight beats.
//   - During reset: out_valid=0, out_shares=0, in_ready=0.
//   - in_ready rises the first cycle after rst is deasserted.
// - Out-of-range parameters abort elaboration via a generate-time error.
// TESTING
// T1: NUM_SHARES=3, mode 0, shares {0x00,0x80,0x01} (s2,s1,s0) -> after PIPE_DEPTH cycles out {0x00,0x58,0x24}; XOR of outputs 0x7C = map(0x81).
// T2: mode 1, shares {0x00,0x00,0x01} -> out {0x00,0x00,0x47}; constant appears only on share 0.
// T3: out_ready=0, push beats 0x01,0x02,... -> exactly PIPE_DEPTH accepted, in_ready=0, out_shares frozen at the first result; release -> beats emerge in order, none dropped.
// T4: out_ready=1, in_valid=1 for 256 cycles sweeping share-0 input 0x00..0xFF -> one result per cycle, each equal to the equations above, with latency PIPE_DEPTH.
// T5: assert rst while the pipeline is full and stalled -> next cycle out_valid=0, out_shares=0; first beat after reset returns correct data.
// T6: random valid/ready toggling, random shares and modes across NUM_SHARES in {2,3,4} and PIPE_DEPTH in {1,4} -> scoreboard match of unshared XOR, order and mode.

Source files
------------

// File: rtl/shared_lin_map_pipe.sv
// Per-share AES output linear map (optional 0x63 on share 0) for threshold
// implementations, behind a PIPE_DEPTH-stage valid/ready pipeline with a registered output.
module shared_lin_map_pipe #(
  parameter int NUM_SHARES = 3,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [8*NUM_SHARES-1:0] in_shares,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*NUM_SHARES-1:0] out_shares
);
  localparam int W = 8 * NUM_SHARES;

  generate
    if (NUM_SHARES < 2 || NUM_SHARES > 8) begin : g_bad_num_shares
      $error("shared_lin_map_pipe: NUM_SHARES must be in 2..8");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_pipe_depth
      $error("shared_lin_map_pipe: PIPE_DEPTH must be in 1..4");
    end
  endgenerate

  function automatic logic [7:0] lin_map(input logic [7:0] c);
    logic [7:0] d;
    d[7] = c[5] ^ c[3];
    d[6] = c[7] ^ c[3];
    d[5] = c[6] ^ c[0];
    d[4] = c[7] ^ c[5] ^ c[3];
    d[3] = c[7] ^ c[6] ^ c[5] ^ c[4] ^ c[3];
    d[2] = c[6] ^ c[5] ^ c[3] ^ c[2] ^ c[0];
    d[1] = c[5] ^ c[4] ^ c[1];
    d[0] = c[6] ^ c[4] ^ c[1];
    return d;
  endfunction

  logic [PIPE_DEPTH-1:0]        valid_q;
  logic [PIPE_DEPTH-1:0]        valid_d;
  logic [PIPE_DEPTH-1:0][W-1:0] data_q;
  logic [PIPE_DEPTH-1:0][W-1:0] data_d;
  logic [PIPE_DEPTH-1:0]        stage_ready;
  logic                         mode0_q;
  logic                         mode0_d;
  logic [W-1:0]                 map_src;
  logic                         map_mode;
  logic [W-1:0]                 mapped;

  // With a single stage the map sits in front of the only (output) register;
  // otherwise it sits between stage 0 and stage 1.
  assign map_src  = (PIPE_DEPTH == 1) ? in_shares : data_q[0];
  assign map_mode = (PIPE_DEPTH == 1) ? in_mode   : mode0_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SHARES; gi++) begin : g_share
      if (gi == 0) begin : g_const
        assign mapped[7:0] = lin_map(map_src[7:0]) ^ (map_mode ? 8'h63 : 8'h00);
      end else begin : g_plain
        assign mapped[8*gi +: 8] = lin_map(map_src[8*gi +: 8]);
      end
    end

    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      logic         stage_vin;
      logic [W-1:0] stage_din;

      // A stage can load if it, or any stage after it, has a free slot this edge.
      assign stage_ready[gi] = out_ready | ~(&valid_q[PIPE_DEPTH-1:gi]);

      if (gi == 0) begin : g_head
        assign stage_vin = in_valid;
        assign stage_din = (PIPE_DEPTH == 1) ? mapped : in_shares;
      end else if (gi == 1) begin : g_map
        assign stage_vin = valid_q[0];
        assign stage_din = mapped;
      end else begin : g_pass
        assign stage_vin = valid_q[gi-1];
        assign stage_din = data_q[gi-1];
      end

      assign valid_d[gi] = stage_ready[gi] ? stage_vin : valid_q[gi];
      assign data_d[gi]  = (stage_ready[gi] && stage_vin) ? stage_din : data_q[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          data_q[gi]  <= data_d[gi];
        end
      end
    end
  endgenerate

  assign mode0_d = (stage_ready[0] && in_valid) ? in_mode : mode0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode0_q <= 1'b0;
    end else begin
      mode0_q <= mode0_d;
    end
  end

  assign in_ready   = stage_ready[0] & ~rst;
  assign out_valid  = valid_q[PIPE_DEPTH-1];
  assign out_shares = data_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_shared_lin_map_pipe.sv
// Scoreboard bench for shared_lin_map_pipe: stimulus pushes expected beats,
// an independent monitor pops and compares each accepted output beat.
module tb_shared_lin_map_pipe;
  localparam int NS = 3;
  localparam int PD = 3;
  localparam int W  = 8 * NS;

  // Row masks of the map: output bit n is the parity of (c & MASK[n]).
  localparam logic [7:0] MASK [8] = '{8'h52, 8'h32, 8'h6D, 8'hF8, 8'hA8, 8'h41, 8'h88, 8'h28};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_shares;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_shares;

  always #5 clk = ~clk;

  shared_lin_map_pipe #(.NUM_SHARES(NS), .PIPE_DEPTH(PD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_shares (in_shares),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_shares(out_shares)
  );

  typedef struct {
    logic [W-1:0] exp;
    int           acc_cyc;
    bit           lat_chk;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  n_cmp     = 0;
  int  n_err     = 0;
  int  cyc       = 0;
  int  rdy_mode  = 1;
  int  stall_cnt = 0;
  int  n_out     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [7:0] ref_map(input logic [7:0] c);
    logic [7:0] d;
    for (int n = 0; n < 8; n++) d[n] = ^(c & MASK[n]);
    return d;
  endfunction

  function automatic logic [W-1:0] ref_shares(input logic [W-1:0] x, input logic mode);
    logic [W-1:0] y;
    for (int i = 0; i < NS; i++) y[8*i +: 8] = ref_map(x[8*i +: 8]);
    if (mode) y[7:0] = y[7:0] ^ 8'h63;
    return y;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a beat transfers on the next rising edge when valid and ready are both high now.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %h, expected no beat", out_shares);
      end else begin
        mon_e = sb.pop_front();
        $display("beat %0d: out=%h exp=%h", n_out, out_shares, mon_e.exp);
        check("beat_data", out_shares, mon_e.exp);
        if (mon_e.lat_chk) check("latency", W'(cyc - mon_e.acc_cyc), W'(PD));
        n_out++;
      end
    end
  end

  task automatic send(input logic [W-1:0] data, input logic mode,
                      input logic [W-1:0] exp, input bit lat);
    int   waited;
    sb_t  e;
    waited = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_shares = data;
    in_mode   = mode;
    #1;
    while (!in_ready) begin
      if (waited > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited > 0) stall_cnt++;
    e.exp     = exp;
    e.acc_cyc = cyc;
    e.lat_chk = lat;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    idle(1);
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
      sb.delete();
    end
    idle(2);
  endtask

  initial begin
    int           accepted;
    logic [7:0]   nxt;
    logic [W-1:0] d;
    logic         m;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_shares = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_out_shares", out_shares, '0);
    check("reset_in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", W'(in_ready), W'(1));

    // Single beats into an empty pipeline, hand-computed results.
    send(24'h008001, 1'b0, 24'h005824, 1'b1);
    drain();
    send(24'h000001, 1'b1, 24'h000047, 1'b1);
    drain();

    // Stall with out_ready low: exactly PD beats fit, output frozen on the first.
    rdy_mode = 0;
    idle(2);
    accepted = 0;
    nxt      = 8'h01;
    for (int k = 0; k < PD + 2; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_mode   = 1'b0;
      in_shares = {16'h0000, nxt};
      #1;
      if (in_ready) begin
        mon_e.exp     = ref_shares({16'h0000, nxt}, 1'b0);
        mon_e.acc_cyc = cyc;
        mon_e.lat_chk = 1'b0;
        sb.push_back(mon_e);
        accepted++;
        nxt++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("stall_accepted", W'(accepted), W'(PD));
    check("stall_in_ready", W'(in_ready), W'(0));
    for (int k = 0; k < 3; k++) begin
      check("stall_out_valid", W'(out_valid), W'(1));
      check("stall_out_frozen", out_shares, 24'h000024);
      @(negedge clk);
      #1;
    end
    rdy_mode = 1;
    drain();

    // Full-rate sweep of share 0 with out_ready held high.
    stall_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      d = {8'h00, 8'(i) ^ 8'h5A, 8'(i)};
      send(d, 1'b0, ref_shares(d, 1'b0), 1'b1);
    end
    check("sweep_no_stall", W'(stall_cnt), W'(0));
    drain();

    // Reset while full and stalled.
    rdy_mode = 0;
    idle(2);
    for (int k = 0; k < PD; k++) send(24'h030201 + W'(k), 1'b1, '0, 1'b0);
    idle(2);
    @(negedge clk);
    rst      = 1'b1;
    rdy_mode = 1;
    sb.delete();
    @(negedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_shares", out_shares, '0);
    check("rst_in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", W'(in_ready), W'(1));
    send(24'h000080, 1'b1, 24'h00003B, 1'b1);
    drain();

    // Random traffic, random gaps and backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      d = W'({$urandom, $urandom});
      m = 1'($urandom_range(0, 1));
      send(d, m, ref_shares(d, m), 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rdy_mode = 1;
    drain();
    check("scoreboard_empty", W'(sb.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
